fp_unit_arb: RTL
================

# fp_unit_arb

Multi-channel issue front end for the floating-point unit. It accepts operations from `NCH` independent requestor channels, each with its own request FIFO. A round-robin arbiter issues them one at a time to a single in-order FP core port. Results come back on the requesting channel through per-channel result FIFOs. Credit-based issue means a completed result never has to be dropped or stalled. The block sits between the integer pipeline or vector lanes and the FP core.

## Interface
Parameters:
- `NCH`, 4: number of requestor channels, ≥2.
- `DEPTH`, 4: depth of each request FIFO and each result FIFO, a power of two ≥2.
- `MAXOUT`, 4: maximum number of operations in flight in the core, a power of two.
- `W`, 128: width of the request payload (operands, op, rounding mode).
- `RW`, 69: width of the result payload (64-bit result plus 5 flag bits).

Ports:
- `clock`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous flush.
- `req_valid`, in, NCH: request valid, one bit per channel.
- `req_ready`, out, NCH: request FIFO not full.
- `req_data`, in, NCH*W: request payloads; channel c uses bits [c*W +: W].
- `rsp_valid`, out, NCH: result FIFO not empty.
- `rsp_ready`, in, NCH: consumer pops the result FIFO.
- `rsp_data`, out, NCH*RW: head entry of each result FIFO.
- `core_valid`, out, 1: an operation is presented to the core.
- `core_ready`, in, 1: the core accepts the operation.
- `core_data`, out, W: payload of the granted operation.
- `core_done`, in, 1: the core has a result this cycle. The core completes operations in issue order.
- `core_result`, in, RW: the result payload.
- `err`, out, 1: sticky protocol error.

## Operation
**Request side**
- A request is pushed when `req_valid[c] & req_ready[c]`.

**Credits**
- Each channel has a credit counter `cred[c]`, reset value `DEPTH`.
- An issue from channel c decrements `cred[c]`.
- A result pop on channel c (`rsp_valid[c] & rsp_ready[c]`) increments `cred[c]`.
- If both happen in the same cycle, `cred[c]` is unchanged.

**Issue eligibility and arbitration**
- Channel c is eligible when its request FIFO is not empty, `cred[c] > 0`, and the tag FIFO is not full.
- Arbitration is round-robin among eligible channels, starting from `rr_ptr`.
- `rr_ptr` resets to 0. After each issue it becomes (granted channel + 1) mod `NCH`. It holds when nothing is issued.
- `core_valid` = any channel eligible. `core_data` = head entry of the granted channel's request FIFO.
- The grant is combinational and may change while `core_ready` is low; no hold on the grant is required.

**Issue**
- An issue occurs on `core_valid & core_ready`.
- On issue: pop the granted request FIFO, push the channel id into the tag FIFO (depth `MAXOUT`), and update `rr_ptr`.

**Completion**
- On `core_done`: pop the tag FIFO and push `core_result` into the result FIFO of the channel named by the popped tag.
- The credit scheme guarantees that this push never sees a full FIFO.
- If `core_done` arrives while the tag FIFO is empty, the result is discarded and `err` is set.

**FIFO boundary cases**
- Every FIFO allows push and pop in the same cycle, including when full; occupancy is then unchanged.
- Read and write pointers wrap modulo the depth.

**Clear**
- `clear` empties all FIFOs and sets `cred` to `DEPTH`, `rr_ptr` to 0 and `err` to 0.
- Any issue, `core_done` or request push in the same cycle as `clear` is ignored.
- `clear` takes priority over every other event.
- The core must be cleared in the same cycle; the system ties both clear inputs together.

**Reset**
- Reset has the same effect as `clear`, applied asynchronously.
- Output reset values: `req_ready` all ones, `rsp_valid` 0, `core_valid` 0, `err` 0, and `rsp_data` / `core_data` 0.

## Timing
- Request FIFOs are registered. A request accepted in cycle t can appear on `core_valid` at t+1 at the earliest.
- For a core latency of L cycles from issue to `core_done`: issue at t+1, `core_done` at t+1+L, `rsp_valid` at t+2+L.
- Throughput is one issue per cycle when `core_ready` is high.
- `req_ready` and `rsp_valid` are driven from registered FIFO state only; there is no combinational path from `req_valid` or `rsp_ready` to them.
- The path from `core_ready` to the FIFO pops is combinational and is the critical path.

## Structure
- Package `fp_arb_wire` holds:
  - typedefs for the request and result payload structs;
  - the channel-id type `logic [$clog2(NCH)-1:0]`;
  - localparams for the pointer widths.
- Sub-module `fp_fifo` is a generic synchronous FIFO with parameters `WIDTH` and `DEPTH`, and ports push, pop, data, full, empty and a synchronous flush. Instantiate it:
  - `NCH` times for request FIFOs;
  - `NCH` times for result FIFOs;
  - once for the tag FIFO.
- Arbiter, credit counters and `err` live in `fp_unit_arb` itself.

## Test plan
- Single request, core L=3: request on channel 2 accepted at cycle 0 → `core_valid` at cycle 1 with `core_data` equal to the request, `rsp_valid[2]` at cycle 5 carrying the result.
- All channels stream with `core_ready` high → grants rotate 0,1,2,3,0…, and each channel receives its results in its own order.
- Channel 1 never asserts `rsp_ready`, `DEPTH`=4 → exactly 4 issues from channel 1, then channel 1 stops being granted while the other channels continue. One pop on channel 1 re-enables exactly one issue.
- Pulse `clear` with 3 operations in flight and all FIFOs partly full → the next cycle shows `rsp_valid` all 0, `req_ready` all 1, and the next grant goes to channel 0.
- `core_done` with no operation outstanding → result dropped, `err`=1 held until `clear`.
- Assert reset (drive it low) mid-stream, asynchronously between clock edges → outputs immediately take their reset values; after release, operation resumes from an empty state.

Source files
------------

// File: rtl/fp_unit_arb_pkg.sv
// Shared types and default sizing for the FP unit issue front end.
package fp_arb_wire;

  localparam int unsigned NCH_DEF    = 4;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned MAXOUT_DEF = 4;
  localparam int unsigned W_DEF      = 128;
  localparam int unsigned RW_DEF     = 69;

  localparam int unsigned CHW   = $clog2(NCH_DEF);
  localparam int unsigned PTRW  = $clog2(DEPTH_DEF);
  localparam int unsigned TAGPW = $clog2(MAXOUT_DEF);

  typedef logic [CHW-1:0] chan_t;

  typedef struct packed {
    logic [2:0]  rm;
    logic [4:0]  op;
    logic [59:0] b;
    logic [59:0] a;
  } req_t;

  typedef struct packed {
    logic [4:0]  flags;
    logic [63:0] value;
  } rsp_t;

endpackage

// File: rtl/fp_unit_arb_if.sv
// Request, result and core-port bundle of the FP issue front end.
interface fp_unit_arb_if
  import fp_arb_wire::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned W   = W_DEF,
  parameter int unsigned RW  = RW_DEF
);
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*W-1:0]  req_data;
  logic [NCH-1:0]    rsp_valid;
  logic [NCH-1:0]    rsp_ready;
  logic [NCH*RW-1:0] rsp_data;
  logic              core_valid;
  logic              core_ready;
  logic [W-1:0]      core_data;
  logic              core_done;
  logic [RW-1:0]     core_result;
  logic              err;

  modport master (
    output req_valid, req_data, rsp_ready, core_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_data, core_valid, core_data, err
  );

  modport slave (
    input  req_valid, req_data, rsp_ready, core_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_data, core_valid, core_data, err
  );
endinterface

// File: rtl/fp_unit_arb_fifo.sv
// Generic synchronous FIFO; push and pop may coincide even when full.
module fp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/fp_unit_arb.sv
// Multi-channel round-robin issue front end with credit-protected result FIFOs.
module fp_unit_arb
  import fp_arb_wire::*;
#(
  parameter int unsigned NCH    = NCH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned MAXOUT = MAXOUT_DEF,
  parameter int unsigned W      = W_DEF,
  parameter int unsigned RW     = RW_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  fp_unit_arb_if.slave bus
);
  localparam int unsigned CW  = $clog2(NCH);
  localparam int unsigned CRW = $clog2(DEPTH) + 1;

  logic [NCH-1:0]    req_full, req_empty, req_pop;
  logic [NCH-1:0]    rsp_full, rsp_empty, rsp_push, rsp_pop, elig;
  logic [W-1:0]      req_head [NCH];
  logic [RW-1:0]     rsp_head [NCH];
  logic [NCH*RW-1:0] rsp_flat;
  logic [CW-1:0]     tag_head, gnt, rr_q, rr_d;
  logic              tag_full, tag_empty, gnt_found, issue, done_ok;
  logic [CRW-1:0]    cred_q [NCH];
  logic [CRW-1:0]    cred_d [NCH];
  logic              err_q, err_d;
  int unsigned       idx;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fp_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_req (
      .clk_i(clock), .rst_ni(reset), .flush_i(clear),
      .push_i(bus.req_valid[c] & ~req_full[c]), .pop_i(req_pop[c]),
      .data_i(bus.req_data[c*W +: W]), .data_o(req_head[c]),
      .full_o(req_full[c]), .empty_o(req_empty[c])
    );
    fp_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_rsp (
      .clk_i(clock), .rst_ni(reset), .flush_i(clear),
      .push_i(rsp_push[c]), .pop_i(bus.rsp_ready[c]),
      .data_i(bus.core_result), .data_o(rsp_head[c]),
      .full_o(rsp_full[c]), .empty_o(rsp_empty[c])
    );
    assign elig[c]     = ~req_empty[c] & (cred_q[c] != '0) & ~tag_full;
    assign req_pop[c]  = issue & (gnt == CW'(c));
    assign rsp_push[c] = done_ok & (tag_head == CW'(c));
    assign rsp_pop[c]  = bus.rsp_ready[c] & ~rsp_empty[c];
  end

  fp_fifo #(.WIDTH(CW), .DEPTH(MAXOUT)) u_tag (
    .clk_i(clock), .rst_ni(reset), .flush_i(clear),
    .push_i(issue), .pop_i(bus.core_done),
    .data_i(gnt), .data_o(tag_head),
    .full_o(tag_full), .empty_o(tag_empty)
  );

  // First eligible channel at or after rr_q, wrapping modulo NCH.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(rr_q) + i) % NCH;
      if (!gnt_found && elig[CW'(idx)]) begin
        gnt_found = 1'b1;
        gnt       = CW'(idx);
      end
    end
  end

  assign issue          = bus.core_valid & bus.core_ready & ~clear;
  assign done_ok        = bus.core_done & ~tag_empty & ~clear;
  assign bus.core_valid = |elig;
  assign bus.core_data  = gnt_found ? req_head[gnt] : '0;
  assign bus.req_ready  = ~req_full;
  assign bus.rsp_valid  = ~rsp_empty;
  assign bus.rsp_data   = rsp_flat;
  assign bus.err        = err_q;

  always_comb begin
    rsp_flat = '0;
    for (int unsigned c = 0; c < NCH; c++)
      rsp_flat[c*RW +: RW] = rsp_empty[c] ? '0 : rsp_head[c];
  end

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      cred_d[c] = cred_q[c];
      if (req_pop[c] && !rsp_pop[c])      cred_d[c] = cred_q[c] - CRW'(1);
      else if (rsp_pop[c] && !req_pop[c]) cred_d[c] = cred_q[c] + CRW'(1);
    end
    rr_d = rr_q;
    if (issue) rr_d = (gnt == CW'(NCH - 1)) ? '0 : gnt + CW'(1);
    // Result overflow cannot happen with correct credits; flag it if it does.
    err_d = err_q | (bus.core_done & tag_empty) | (|(rsp_push & rsp_full & ~rsp_pop));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q  <= '0;
      err_q <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) cred_q[c] <= CRW'(DEPTH);
    end else if (clear) begin
      rr_q  <= '0;
      err_q <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) cred_q[c] <= CRW'(DEPTH);
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
      for (int unsigned c = 0; c < NCH; c++) cred_q[c] <= cred_d[c];
    end
  end
endmodule
